// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU sequencer and the 8-bit alu it drives.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PASS = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Runs one NBYTES-wide ADD/SUB/AND/OR through an external 8-bit combinational alu,
// least-significant byte first, chaining carry/borrow with an extra +1/-1 fix-up pass.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_opcode,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_res,
    output logic                  rsp_carry,
    output logic [1:0]            alu_opcode,
    output logic [ALU_W-1:0]      alu_a,
    output logic [ALU_W-1:0]      alu_b,
    input  logic [ALU_W-1:0]      alu_res,
    input  logic                  alu_carry
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    seq_state_t             state;
    logic [IDXW-1:0]        idx;
    logic [IDXW-1:0]        next_idx;
    logic                   chain;
    logic                   c1_q;
    logic [W-1:0]           a_q;
    logic [W-1:0]           b_q;
    logic [W-1:0]           res_q;
    logic [W-1:0]           res_next;
    logic [ALU_W-1:0]       next_a;
    logic [ALU_W-1:0]       next_b;
    logic                   arith;
    logic                   last;
    logic                   need_fix;
    logic                   adv_chain;

    // The byte written back is always the current alu_res, whether from a plain pass or a fix-up.
    always_comb begin
        arith     = ~alu_opcode[1];
        last      = (idx == IDXW'(NBYTES - 1));
        next_idx  = idx + 1'b1;
        need_fix  = (state == PASS) && arith && chain;
        adv_chain = (state == FIX) ? (c1_q | alu_carry) : (arith & alu_carry);
        res_next  = res_q;
        res_next[8*idx +: 8] = alu_res;
        next_a    = a_q[8*next_idx +: 8];
        next_b    = b_q[8*next_idx +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_res    <= '0;
            rsp_carry  <= 1'b0;
            alu_opcode <= OP_ADD;
            alu_a      <= '0;
            alu_b      <= '0;
            idx        <= '0;
            chain      <= 1'b0;
            c1_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q        <= req_a;
                        b_q        <= req_b;
                        alu_opcode <= req_opcode;
                        alu_a      <= req_a[7:0];
                        alu_b      <= req_b[7:0];
                        idx        <= '0;
                        chain      <= 1'b0;
                        req_ready  <= 1'b0;
                        state      <= PASS;
                    end
                end
                PASS, FIX: begin
                    if (need_fix) begin
                        // Fold the incoming carry/borrow in as a +1/-1 on this byte's raw result.
                        alu_a <= alu_res;
                        alu_b <= 8'h01;
                        c1_q  <= alu_carry;
                        state <= FIX;
                    end else begin
                        res_q <= res_next;
                        chain <= adv_chain;
                        if (last) begin
                            rsp_res   <= res_next;
                            rsp_carry <= adv_chain;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx   <= next_idx;
                            alu_a <= next_a;
                            alu_b <= next_b;
                            state <= PASS;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer (NBYTES=2) with a behavioural 8-bit alu on its alu ports.
module tb_alu_sequencer;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_opcode;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_res;
    logic          rsp_carry;
    logic [1:0]    alu_opcode;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [7:0]    alu_res;
    logic          alu_carry;

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;
    int   accept_cycle = 0;

    alu_sequencer #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_carry(rsp_carry),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference 8-bit alu: carry is the ADD carry-out or the SUB borrow-out.
    always_comb begin
        logic [8:0] sum;
        sum       = 9'd0;
        alu_res   = 8'h00;
        alu_carry = 1'b0;
        case (alu_opcode)
            2'b00: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_res = sum[7:0]; alu_carry = sum[8]; end
            2'b01: begin alu_res = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            2'b10: alu_res = alu_a & alu_b;
            default: alu_res = alu_a | alu_b;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level expectation, with latency from the carry/borrow into each upper byte.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] wide;
        longint mask, la, lb;
        e.lat = NB;
        case (op)
            2'b00: begin wide = {1'b0, a} + {1'b0, b}; e.res = wide[W-1:0]; e.carry = wide[W]; end
            2'b01: begin e.res = a - b; e.carry = (a < b); end
            2'b10: begin e.res = a & b; e.carry = 1'b0; end
            default: begin e.res = a | b; e.carry = 1'b0; end
        endcase
        if (op[1] == 1'b0) begin
            for (int i = 1; i < NB; i++) begin
                mask = (longint'(1) << (8 * i)) - 1;
                la = longint'(a) & mask;
                lb = longint'(b) & mask;
                if (op == 2'b00 && ((la + lb) >> (8 * i)) != 0) e.lat++;
                if (op == 2'b01 && la < lb) e.lat++;
            end
        end
        return e;
    endfunction

    task automatic presentRequest(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        sb.push_back(model(op, a, b));
    endtask

    task automatic waitAccept();
        logic rdy;
        for (int n = 0; n < 20; n++) begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                accept_cycle = cycle;
                req_valid = 1'b0;
                return;
            end
        end
        checkOutput("accept_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        presentRequest(op, a, b);
        waitAccept();
    endtask

    // Waits for rsp_valid, then compares against the oldest scoreboard entry.
    task automatic collectResponse(input string tag);
        exp_t e;
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rsp_valid) begin
            checkOutput({tag, "_rsp_timeout"}, 64'(rsp_valid), 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checkOutput({tag, "_res"}, 64'(rsp_res), 64'(e.res));
        checkOutput({tag, "_carry"}, 64'(rsp_carry), 64'(e.carry));
        checkOutput({tag, "_lat"}, 64'(cycle - accept_cycle), 64'(e.lat));
    endtask

    task automatic finishHandshake(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] held_res;
        logic         held_carry;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;

        rst = 1'b1; req_valid = 1'b0; req_opcode = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_res", 64'(rsp_res), 64'd0);
        checkOutput("rst_rsp_carry", 64'(rsp_carry), 64'd0);
        checkOutput("rst_alu_ports", 64'({alu_opcode, alu_a, alu_b}), 64'd0);

        applyStimulus(2'b00, 16'h00FF, 16'h0001); collectResponse("add_fix");   finishHandshake("add_fix");
        applyStimulus(2'b00, 16'hFFFF, 16'h0001); collectResponse("add_wrap");  finishHandshake("add_wrap");
        applyStimulus(2'b01, 16'h0100, 16'h0001); collectResponse("sub_fix");   finishHandshake("sub_fix");
        applyStimulus(2'b01, 16'h0000, 16'h0001); collectResponse("sub_wrap");  finishHandshake("sub_wrap");
        applyStimulus(2'b10, 16'h0F0F, 16'h00FF); collectResponse("and");       finishHandshake("and");
        applyStimulus(2'b11, 16'h0000, 16'hFFFF); collectResponse("or");        finishHandshake("or");

        // Backpressure: response must hold while a second request waits its turn.
        rsp_ready = 1'b0;
        applyStimulus(2'b00, 16'h00FF, 16'h0001);
        collectResponse("bp_first");
        held_res   = rsp_res;
        held_carry = rsp_carry;
        presentRequest(2'b10, 16'h0F0F, 16'h00FF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid_hold", 64'(rsp_valid), 64'd1);
            checkOutput("bp_res_hold", 64'(rsp_res), 64'(held_res));
            checkOutput("bp_carry_hold", 64'(rsp_carry), 64'(held_carry));
            checkOutput("bp_req_ready_low", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        finishHandshake("bp_first");
        waitAccept();
        collectResponse("bp_second");
        finishHandshake("bp_second");

        // Reset while byte 1 is in its first pass.
        applyStimulus(2'b00, 16'h00FF, 16'h0001);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_front());
        checkOutput("midrst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("midrst_alu_ports", 64'({alu_opcode, alu_a, alu_b}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        applyStimulus(2'b00, 16'h1234, 16'h1111); collectResponse("post_rst"); finishHandshake("post_rst");

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = W'($urandom);
            rb  = W'($urandom);
            applyStimulus(rop, ra, rb);
            collectResponse("rand");
            finishHandshake("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
